// File: rtl/aes_v2_sub_arbiter_pkg.sv
// Shared definitions for the SubBytes arbiter slice.
//   state_t      : arbiter FSM states (IDLE / EXEC / DONE)
//   PORT0/PORT1  : port-index constants used by the grant and priority registers
//   sbox()       : AES forward/inverse S-box, computed as a GF(2^8) inverse
//                  plus affine transform so no 256-entry table is needed.
package aes_v2_sub_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic enc);
        logic [7:0] y;
        if (enc) begin
            y = gf_inv(x);
            return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
        end
        y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/aes_v2_sub_latency.sv
// SubBytes datapath: substitutes one byte from each of four lanes
// (rs1[7:0], rs2[15:8], rs1[23:16], rs2[31:24]) and optionally rotates the word.
//   valid  : output is forced to zero when low
//   rs1/rs2: source operands
//   enc    : 1 = forward S-box, 0 = inverse S-box
//   rot    : 1 = result {out2,out1,out0,out3}, 0 = {out3,out2,out1,out0}
//   result : 32-bit substituted word
module aes_v2_sub_latency
    import aes_v2_sub_arbiter_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    input  logic        rot,
    output logic [31:0] result
);

    logic [7:0] out0, out1, out2, out3;

    // Bytes not selected by the lane pattern are intentionally ignored.
    logic unused_bytes;
    assign unused_bytes = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

    always_comb begin
        out0 = sbox(rs1[7:0],   enc);
        out1 = sbox(rs2[15:8],  enc);
        out2 = sbox(rs1[23:16], enc);
        out3 = sbox(rs2[31:24], enc);
        result = '0;
        if (valid) begin
            result = rot ? {out2, out1, out0, out3} : {out3, out2, out1, out0};
        end
    end

endmodule

// File: rtl/aes_v2_sub_arbiter.sv
// Two-port arbiter in front of a shared SubBytes datapath.
// One operation per three cycles: IDLE (grant + latch), EXEC (compute),
// DONE (one-cycle ready to the granted port).
//   FAIR            : 1 = round-robin between ports, 0 = fixed priority to port 0
//   g_clk / g_rst   : clock, synchronous active-high reset
//   reqN_valid      : request, held until reqN_ready
//   reqN_rs1/rs2    : source operands
//   reqN_enc/rot    : forward(1)/inverse(0) S-box; rotate result word
//   reqN_ready      : one-cycle result pulse for port N
//   reqN_rd         : result word (shared result register)
//   busy            : FSM is not in IDLE
module aes_v2_sub_arbiter
    import aes_v2_sub_arbiter_pkg::*;
#(
    parameter int unsigned FAIR = 1
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic        req0_enc,
    input  logic        req0_rot,
    output logic        req0_ready,
    output logic [31:0] req0_rd,
    input  logic        req1_valid,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic        req1_enc,
    input  logic        req1_rot,
    output logic        req1_ready,
    output logic [31:0] req1_rd,
    output logic        busy
);

    state_t      state;
    logic        ptr;
    logic        grant;
    logic        pick;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
    logic        op_enc;
    logic        op_rot;
    logic [31:0] result;
    logic [31:0] sub_result;

    aes_v2_sub_latency u_sub (
        .valid  (state == EXEC),
        .rs1    (op_rs1),
        .rs2    (op_rs2),
        .enc    (op_enc),
        .rot    (op_rot),
        .result (sub_result)
    );

    always_comb begin
        pick = PORT0;
        if (req0_valid && req1_valid) begin
            pick = (FAIR != 0) ? ptr : PORT0;
        end else if (req1_valid) begin
            pick = PORT1;
        end
    end

    // Ready is registered on the EXEC->DONE transition so it is high
    // exactly for the DONE cycle.
    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state      <= IDLE;
            ptr        <= PORT0;
            grant      <= PORT0;
            op_rs1     <= '0;
            op_rs2     <= '0;
            op_enc     <= 1'b0;
            op_rot     <= 1'b0;
            result     <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant  <= pick;
                        op_rs1 <= (pick == PORT1) ? req1_rs1 : req0_rs1;
                        op_rs2 <= (pick == PORT1) ? req1_rs2 : req0_rs2;
                        op_enc <= (pick == PORT1) ? req1_enc : req0_enc;
                        op_rot <= (pick == PORT1) ? req1_rot : req0_rot;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    result     <= sub_result;
                    req0_ready <= (grant == PORT0);
                    req1_ready <= (grant == PORT1);
                    state      <= DONE;
                end
                DONE: begin
                    if (FAIR != 0) ptr <= ~grant;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign req0_rd = result;
    assign req1_rd = result;

endmodule

// File: tb/tb_aes_v2_sub_arbiter.sv
// Directed bench for aes_v2_sub_arbiter. Two instances share the stimulus:
// dut (round-robin) and dut_fp (fixed priority).
module tb_aes_v2_sub_arbiter;

    logic        g_clk = 1'b0;
    logic        g_rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic        req0_enc, req0_rot, req1_enc, req1_rot;
    logic        req0_ready, req1_ready, busy;
    logic [31:0] req0_rd, req1_rd;
    logic        fp_req0_ready, fp_req1_ready, fp_busy;
    logic [31:0] fp_req0_rd, fp_req1_rd;

    int checks   = 0;
    int failures = 0;

    always #5 g_clk = ~g_clk;

    aes_v2_sub_arbiter #(.FAIR(1)) dut (
        .g_clk(g_clk), .g_rst(g_rst),
        .req0_valid(req0_valid), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_enc(req0_enc), .req0_rot(req0_rot), .req0_ready(req0_ready), .req0_rd(req0_rd),
        .req1_valid(req1_valid), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_enc(req1_enc), .req1_rot(req1_rot), .req1_ready(req1_ready), .req1_rd(req1_rd),
        .busy(busy)
    );

    aes_v2_sub_arbiter #(.FAIR(0)) dut_fp (
        .g_clk(g_clk), .g_rst(g_rst),
        .req0_valid(req0_valid), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_enc(req0_enc), .req0_rot(req0_rot), .req0_ready(fp_req0_ready), .req0_rd(fp_req0_rd),
        .req1_valid(req1_valid), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_enc(req1_enc), .req1_rot(req1_rot), .req1_ready(fp_req1_ready), .req1_rd(fp_req1_rd),
        .busy(fp_busy)
    );

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single-port operation: request, EXEC, DONE with ready, back to IDLE.
    task automatic op(input string tag, input logic port, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic enc, input logic rot,
                      input logic [31:0] exp);
        if (port) begin
            req1_valid = 1'b1; req1_rs1 = rs1; req1_rs2 = rs2; req1_enc = enc; req1_rot = rot;
        end else begin
            req0_valid = 1'b1; req0_rs1 = rs1; req0_rs2 = rs2; req0_enc = enc; req0_rot = rot;
        end
        tick();
        chk({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_exec_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        chk({tag, "_done_ready"}, {30'd0, req1_ready, req0_ready}, port ? 32'd2 : 32'd1);
        chk({tag, "_rd"}, port ? req1_rd : req0_rd, exp);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk({tag, "_idle"}, {29'd0, busy, req1_ready, req0_ready}, 32'd0);
    endtask

    initial begin
        g_rst = 1'b1;
        req0_valid = 1'b0; req0_rs1 = '0; req0_rs2 = '0; req0_enc = 1'b0; req0_rot = 1'b0;
        req1_valid = 1'b0; req1_rs1 = '0; req1_rs2 = '0; req1_enc = 1'b0; req1_rot = 1'b0;
        tick();
        tick();
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("rst_rd0", req0_rd, 32'd0);
        chk("rst_rd1", req1_rd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fp", {29'd0, fp_busy, fp_req1_ready, fp_req0_ready}, 32'd0);
        g_rst = 1'b0;
        tick();
        chk("idle_no_req", {31'd0, busy}, 32'd0);

        op("p0_zero",     1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h63636363);
        op("p1_one",      1'b1, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 32'h6363637c);
        op("p1_one_rot",  1'b1, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 32'h63637c63);
        op("p0_inv",      1'b0, 32'h63636363, 32'h63636363, 1'b0, 1'b0, 32'h00000000);
        op("p0_lanes",    1'b0, 32'hAA53BB02, 32'hFF3C10DD, 1'b1, 1'b0, 32'h16edca77);
        op("p1_lanes_rot",1'b1, 32'hAA53BB02, 32'hFF3C10DD, 1'b1, 1'b1, 32'hedca7716);
        op("p0_inv_lanes",1'b0, 32'h00ED00CA, 32'h7C001600, 1'b0, 1'b0, 32'h0153ff10);

        // Both ports valid continuously.
        g_rst = 1'b1;
        tick();
        g_rst = 1'b0;
        req0_valid = 1'b1; req0_rs1 = 32'h00000000; req0_rs2 = '0; req0_enc = 1'b1; req0_rot = 1'b0;
        req1_valid = 1'b1; req1_rs1 = 32'h00000001; req1_rs2 = '0; req1_enc = 1'b1; req1_rot = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("both_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
            chk("rr_ready", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rd", req0_rd, (k % 2 == 0) ? 32'h63636363 : 32'h6363637c);
            chk("fp_ready", {30'd0, fp_req1_ready, fp_req0_ready}, 32'd1);
            chk("fp_rd", fp_req0_rd, 32'h63636363);
            tick();
            chk("both_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Operands change and valid drops right after the grant.
        req0_valid = 1'b1; req0_rs1 = 32'h00000001; req0_rs2 = '0; req0_enc = 1'b1; req0_rot = 1'b0;
        tick();
        req0_valid = 1'b0; req0_rs1 = '1; req0_rs2 = '1; req0_enc = 1'b0; req0_rot = 1'b1;
        tick();
        chk("latched_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        chk("latched_rd", req0_rd, 32'h6363637c);
        tick();

        // Reset during EXEC aborts the operation and restores pointer to port 0.
        req1_valid = 1'b1; req1_rs1 = 32'h00000001; req1_rs2 = '0; req1_enc = 1'b1; req1_rot = 1'b0;
        tick();
        chk("abort_exec_busy", {31'd0, busy}, 32'd1);
        g_rst = 1'b1;
        tick();
        chk("abort_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rd", req1_rd, 32'd0);
        g_rst = 1'b0;
        req0_valid = 1'b1; req0_rs1 = 32'h00000000; req0_rs2 = '0; req0_enc = 1'b1; req0_rot = 1'b0;
        tick();
        chk("after_abort_ready_exec", {30'd0, req1_ready, req0_ready}, 32'd0);
        tick();
        chk("after_abort_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        chk("after_abort_rd", req0_rd, 32'h63636363);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_v2_sub_arbiter.md
AES_V2_SUB_ARBITER -- requirements
Module: aes_v2_sub_arbiter

Interface
REQ-001 SHALL have parameter: FAIR, 1, 1 = round-robin arbitration; 0 = fixed priority to port 0.
REQ-002 SHALL have port: g_clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: g_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req0_valid  input  1  port 0 request; held high until req0_ready.
REQ-005 SHALL have ports: req0_rs1 / req0_rs2  input  32  port 0 source operands.
REQ-006 SHALL have ports: req0_enc / req0_rot  input  1  port 0 encrypt (set) / decrypt (clear); rotate output word.
REQ-007 SHALL have port: req0_ready  output  1  one-cycle pulse; port 0 result valid.
REQ-008 SHALL have port: req0_rd  output  32  port 0 result; meaningful only while req0_ready.
REQ-009 SHALL have ports: req1_valid, req1_rs1, req1_rs2, req1_enc, req1_rot, req1_ready, req1_rd, identical to port 0.
REQ-010 SHALL have port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, DONE; reset state IDLE.
REQ-012 In IDLE with no valid request, SHALL remain in IDLE.
REQ-013 In IDLE with one or more valid requests, SHALL grant one port, latch its rs1/rs2/enc/rot into operand registers and a 1-bit grant register, and go to EXEC.
REQ-014 When both ports are valid in IDLE and FAIR=1, SHALL grant the port indicated by the priority pointer; with FAIR=0 it SHALL grant port 0.
REQ-015 Priority pointer SHALL point to the non-granted port after every DONE cycle (FAIR=1 only); its reset value is port 0.
REQ-016 In EXEC, SHALL drive the SubBytes datapath from the latched operands only, capture its 32-bit output into the result register, and go to DONE.
REQ-017 SubBytes datapath SHALL apply sbox to bytes rs1[7:0], rs2[15:8], rs1[23:16], rs2[31:24] (out0..out3), forward if enc=1, inverse if enc=0.
REQ-018 The result word SHALL be {out3,out2,out1,out0} when rot=0 and {out2,out1,out0,out3} when rot=1.
REQ-019 In DONE, SHALL assert ready for the granted port only, for exactly one cycle, with its rd equal to the result register, then go to IDLE.
REQ-020 Non-granted port's ready SHALL stay 0; both rd outputs SHALL be driven from the result register.
REQ-021 Latency SHALL be 3 cycles from a sampled valid in IDLE to ready; throughput is one operation per 3 cycles.
REQ-022 Operand changes or valid deassertion after grant SHALL NOT affect the in-flight result; ready SHALL still pulse in DONE.
REQ-023 A request arriving while busy SHALL wait; it is considered only in the next IDLE cycle.
REQ-024 A port whose valid stays high after its ready pulse SHALL be treated as a new request.

Reset
REQ-025 While g_rst=1 at a clock edge: state IDLE, pointer port 0, grant register, operand registers and result register 0.
REQ-026 Reset outputs SHALL be req0_ready=0, req1_ready=0, req0_rd=0, req1_rd=0, busy=0.
REQ-027 Reset asserted in EXEC or DONE SHALL abort the operation with no ready pulse.

Structure
REQ-028 State encoding (IDLE/EXEC/DONE) and the port-index constants SHALL live in the shared AES package.
REQ-029 The SubBytes datapath SHALL be one instance of aes_v2_sub_latency with valid tied to (state==EXEC).
REQ-030 No other sub-module SHALL be used; arbitration, FSM and registers are local.

Verification
REQ-031 Port 0 only, rs1=0x00000000, rs2=0x00000000, enc=1, rot=0 -> req0_ready pulses 3 cycles later with req0_rd=0x63636363; req1_ready stays 0.
REQ-032 Port 1 only, rs1=0x00000001, rs2=0, enc=1: rot=0 -> req1_rd=0x6363637c; rot=1 -> req1_rd=0x63637c63.
REQ-033 Port 0, rs1=0x63636363, rs2=0x63636363, enc=0, rot=0 -> req0_rd=0x00000000.
REQ-034 Both valid continuously, FAIR=1 -> grants alternate 0,1,0,1 with a ready every 3 cycles; with FAIR=0 -> port 0 is always granted.
REQ-035 Change port 0 operands one cycle after grant -> result matches the latched operands; g_rst pulsed in EXEC -> no ready, busy=0, next grant goes to port 0.
